// File: rtl/ook_frame_encoder_if.sv
// Command handshake between the host logic and the OOK frame encoder.
// The host drives valid/data; the encoder reports ready while idle.
interface ook_frame_encoder_if #(
    parameter int NBITS = 24
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [NBITS-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ook_frame_encoder.sv
// On/off keying envelope generator: sync chip, sync low, pulse-width coded bits and
// an inter-frame gap, repeated REPEATS times for each accepted command word.
module ook_frame_encoder #(
    parameter int CHIP_CYCLES    = 4200,
    parameter int NBITS          = 24,
    parameter int REPEATS        = 4,
    parameter int SYNC_LOW_CHIPS = 8,
    parameter int GAP_CHIPS      = 30
) (
    input  logic                  ref_12mhz,
    input  logic                  rst,
    ook_frame_encoder_if.slave    cmd,
    input  logic                  abort,
    output logic                  key,
    output logic                  busy,
    output logic                  done
);

    localparam int CHIP_W = $clog2(CHIP_CYCLES);
    localparam int PH_MAX = (SYNC_LOW_CHIPS > GAP_CHIPS) ? SYNC_LOW_CHIPS : GAP_CHIPS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BIT_W  = $clog2(NBITS + 1);
    localparam int REP_W  = $clog2(REPEATS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_HI,
        SYNC_LO,
        DATA,
        GAP
    } state_t;

    state_t            state_q,    state_nx;
    logic [CHIP_W-1:0] chip_cnt_q, chip_cnt_nx;
    logic [PH_W-1:0]   phase_q,    phase_nx;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_nx;
    logic [1:0]        sub_q,      sub_nx;
    logic [REP_W-1:0]  rep_q,      rep_nx;
    logic [NBITS-1:0]  shadow_q,   shadow_nx;
    logic [NBITS-1:0]  data_sr_q,  data_sr_nx;
    logic              key_q,      key_nx;
    logic              busy_q,     busy_nx;
    logic              done_q,     done_nx;
    logic              chip_end;

    assign cmd.cmd_ready = (state_q == IDLE);
    assign key           = key_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge ref_12mhz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chip_cnt_q <= '0;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            sub_q      <= '0;
            rep_q      <= '0;
            shadow_q   <= '0;
            data_sr_q  <= '0;
            key_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nx;
            chip_cnt_q <= chip_cnt_nx;
            phase_q    <= phase_nx;
            bit_cnt_q  <= bit_cnt_nx;
            sub_q      <= sub_nx;
            rep_q      <= rep_nx;
            shadow_q   <= shadow_nx;
            data_sr_q  <= data_sr_nx;
            key_q      <= key_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
        end
    end

    assign chip_end = (chip_cnt_q == CHIP_W'(CHIP_CYCLES - 1));

    always_comb begin
        state_nx    = state_q;
        chip_cnt_nx = chip_cnt_q;
        phase_nx    = phase_q;
        bit_cnt_nx  = bit_cnt_q;
        sub_nx      = sub_q;
        rep_nx      = rep_q;
        shadow_nx   = shadow_q;
        data_sr_nx  = data_sr_q;
        done_nx     = 1'b0;
        key_nx      = 1'b0;
        busy_nx     = 1'b0;

        if (state_q != IDLE) begin
            chip_cnt_nx = chip_end ? '0 : chip_cnt_q + CHIP_W'(1);
        end

        // Phase transitions happen only on the last clock of a chip, so key never changes mid-chip.
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && !abort) begin
                    state_nx    = SYNC_HI;
                    shadow_nx   = cmd.cmd_data;
                    data_sr_nx  = cmd.cmd_data;
                    rep_nx      = '0;
                    chip_cnt_nx = '0;
                end
            end
            SYNC_HI: begin
                if (chip_end) begin
                    state_nx = SYNC_LO;
                    phase_nx = '0;
                end
            end
            SYNC_LO: begin
                if (chip_end) begin
                    if (phase_q == PH_W'(SYNC_LOW_CHIPS - 1)) begin
                        state_nx   = DATA;
                        phase_nx   = '0;
                        bit_cnt_nx = '0;
                        sub_nx     = '0;
                    end else begin
                        phase_nx = phase_q + PH_W'(1);
                    end
                end
            end
            DATA: begin
                if (chip_end) begin
                    if (sub_q == 2'd2) begin
                        sub_nx     = '0;
                        data_sr_nx = data_sr_q << 1;
                        if (bit_cnt_q == BIT_W'(NBITS - 1)) begin
                            state_nx   = GAP;
                            bit_cnt_nx = '0;
                            phase_nx   = '0;
                        end else begin
                            bit_cnt_nx = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        sub_nx = sub_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (chip_end) begin
                    if (phase_q == PH_W'(GAP_CHIPS - 1)) begin
                        phase_nx = '0;
                        if (rep_q == REP_W'(REPEATS - 1)) begin
                            state_nx = IDLE;
                            rep_nx   = '0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx   = SYNC_HI;
                            rep_nx     = rep_q + REP_W'(1);
                            data_sr_nx = shadow_q;
                        end
                    end else begin
                        phase_nx = phase_q + PH_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over every other event, including a frame that is just completing.
        if (abort && state_q != IDLE) begin
            state_nx    = IDLE;
            chip_cnt_nx = '0;
            phase_nx    = '0;
            bit_cnt_nx  = '0;
            sub_nx      = '0;
            rep_nx      = '0;
            done_nx     = 1'b0;
        end

        busy_nx = (state_nx != IDLE);
        unique case (state_nx)
            SYNC_HI: key_nx = 1'b1;
            DATA:    key_nx = (sub_nx == 2'd0) ? 1'b1 :
                              (sub_nx == 2'd1) ? data_sr_nx[NBITS-1] : 1'b0;
            default: key_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ook_frame_encoder.sv
// Directed bench for ook_frame_encoder with small parameters: 4-clock chips, 4-bit words,
// 2 repeats, 18-chip (72-clock) frames.
module tb_ook_frame_encoder;

    localparam int CHIP_CYCLES    = 4;
    localparam int NBITS          = 4;
    localparam int REPEATS        = 2;
    localparam int SYNC_LOW_CHIPS = 2;
    localparam int GAP_CHIPS      = 3;
    localparam int FRAME_CLKS     = 72;
    localparam int SEQ_CLKS       = FRAME_CLKS * REPEATS;

    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic key;
    logic busy;
    logic done;
    int   test_count = 0;
    int   fail_count = 0;

    ook_frame_encoder_if #(.NBITS(NBITS)) cmd_if ();

    ook_frame_encoder #(
        .CHIP_CYCLES    (CHIP_CYCLES),
        .NBITS          (NBITS),
        .REPEATS        (REPEATS),
        .SYNC_LOW_CHIPS (SYNC_LOW_CHIPS),
        .GAP_CHIPS      (GAP_CHIPS)
    ) dut (
        .ref_12mhz (clk),
        .rst       (rst),
        .cmd       (cmd_if.slave),
        .abort     (abort),
        .key       (key),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Expected key for clock `cyc` (1-based) after acceptance: chips 0 sync, 1-2 low, 3-14 data, 15-17 gap.
    function automatic int expKey(input logic [3:0] d, input int cyc);
        int chip;
        int b;
        int s;
        chip = ((cyc - 1) % FRAME_CLKS) / CHIP_CYCLES;
        if (chip == 0) return 1;
        if (chip < 3 || chip >= 15) return 0;
        b = (chip - 3) / 3;
        s = (chip - 3) % 3;
        if (s == 0) return 1;
        if (s == 1) return int'(d[3 - b]);
        return 0;
    endfunction

    // Caller sits at a negedge; the command is accepted at the following posedge.
    task automatic applyStimulus(input logic [3:0] d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = d;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic runSequence(input logic [3:0] d, input int exp_high, input string name);
        int hi [REPEATS];
        for (int r = 0; r < REPEATS; r++) hi[r] = 0;
        for (int cyc = 1; cyc <= SEQ_CLKS; cyc++) begin
            @(negedge clk);
            checkOutput($sformatf("%s key c%0d", name, cyc), int'(key), expKey(d, cyc));
            checkOutput($sformatf("%s busy c%0d", name, cyc), int'(busy), 1);
            checkOutput($sformatf("%s done c%0d", name, cyc), int'(done), 0);
            if (key) hi[(cyc - 1) / FRAME_CLKS]++;
            // Disturb data and valid while busy; neither may affect the frames.
            cmd_if.cmd_data  = cmd_if.cmd_data ^ 4'(cyc);
            cmd_if.cmd_valid = (cyc < SEQ_CLKS - 4) && cyc[0];
        end
        cmd_if.cmd_valid = 1'b0;
        for (int r = 0; r < REPEATS; r++)
            checkOutput($sformatf("%s high f%0d", name, r), hi[r], exp_high);
    endtask

    task automatic checkDoneCycle(input string name);
        @(negedge clk);
        checkOutput({name, " done pulse"}, int'(done), 1);
        checkOutput({name, " ready at done"}, int'(cmd_if.cmd_ready), 1);
        checkOutput({name, " key at done"}, int'(key), 0);
        checkOutput({name, " busy at done"}, int'(busy), 0);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " key"}, int'(key), 0);
        checkOutput({name, " busy"}, int'(busy), 0);
        checkOutput({name, " done"}, int'(done), 0);
        checkOutput({name, " ready"}, int'(cmd_if.cmd_ready), 1);
    endtask

    initial begin
        rst              = 1'b1;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = '0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("post reset");

        applyStimulus(4'b1010);
        runSequence(4'b1010, 28, "w1010");
        checkDoneCycle("w1010");
        @(negedge clk);
        checkOutput("done one cycle", int'(done), 0);

        applyStimulus(4'b0000);
        runSequence(4'b0000, 20, "w0000");
        checkDoneCycle("w0000");
        // Issued inside the done cycle: the next sequence must start without an idle gap.
        applyStimulus(4'b1111);
        runSequence(4'b1111, 36, "w1111");
        checkDoneCycle("w1111");
        @(negedge clk);

        applyStimulus(4'b1010);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            checkOutput($sformatf("pre-abort key c%0d", cyc), int'(key), expKey(4'b1010, cyc));
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkIdle("after abort");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("no done after abort", int'(done), 0);
        end
        applyStimulus(4'b0110);
        runSequence(4'b0110, 28, "w0110");
        checkDoneCycle("w0110");
        @(negedge clk);

        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 4'b1111;
        abort            = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        abort            = 1'b0;
        @(negedge clk);
        checkIdle("abort with valid");

        applyStimulus(4'b1111);
        @(negedge clk);
        checkOutput("sync key before rst", int'(key), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst key", int'(key), 0);
        checkOutput("async rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkIdle("after rst");
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
